// File: rtl/data_mem_unit.sv
// Word-addressed data memory slave with a request/acknowledge FSM and programmable wait states.
// Optional out-of-window checking and the ERR port are enabled by defining DMEM_ERR_EN.
module data_mem_unit #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1730,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        READY
`ifdef DMEM_ERR_EN
    ,
    output logic        ERR
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        wr_q;
    logic [31:0] rdata_q;

    logic [31:0] acc_addr, acc_wdata;
    logic        acc_wr;
    logic [AW-1:0] idx;
    logic        in_win;
    logic        enter_done;

    logic [31:0] mem [DEPTH];

    // In IDLE the access being started is the live request, so a zero-wait access
    // can commit on the very edge that samples CS.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wr    = wr_q;
        if (state_q == S_IDLE) begin
            acc_addr  = ADDR;
            acc_wdata = Data_BUS_WRITE;
            acc_wr    = WR_RD;
        end
        idx = AW'(acc_addr - BASE_ADDR);
`ifdef DMEM_ERR_EN
        in_win = (acc_addr >= BASE_ADDR) && (acc_addr <= (BASE_ADDR + 32'(DEPTH) - 32'd1));
`else
        in_win = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (CS) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_done && !acc_wr) begin
                rdata_q <= in_win ? mem[idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && CS) begin
            addr_q  <= ADDR;
            wdata_q <= Data_BUS_WRITE;
            wr_q    <= WR_RD;
        end
    end

    // NOTE: the RAM array is deliberately not reset; reset only blocks a pending commit.
    always_ff @(posedge CLK) begin
        if (!RST && enter_done && acc_wr && in_win) begin
            mem[idx] <= acc_wdata;
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q;

    always_ff @(posedge CLK) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= enter_done && !in_win;
    end

    assign ERR = err_q;
`endif

    assign Data_BUS_READ = rdata_q;
    assign READY         = (state_q == S_DONE);

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed scoreboard bench for data_mem_unit; expected read data is queued at request time
// and popped on each READY pulse. Builds with or without DMEM_ERR_EN.
module tb_data_mem_unit;

    localparam int WS = 1;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [31:0] ADDR;
    logic        CS;
    logic        WR_RD;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        READY;
`ifdef DMEM_ERR_EN
    logic        ERR;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];
    logic [31:0] last_rd;

    data_mem_unit #(
        .BASE_ADDR  (32'h0000_1730),
        .DEPTH      (1024),
        .WAIT_STATES(WS)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ADDR          (ADDR),
        .CS            (CS),
        .WR_RD         (WR_RD),
        .Data_BUS_WRITE(Data_BUS_WRITE),
        .Data_BUS_READ (Data_BUS_READ),
        .READY         (READY)
`ifdef DMEM_ERR_EN
        ,
        .ERR           (ERR)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (READY !== 1'b1) check({tag, "_timeout"}, 32'(READY), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, Data_BUS_READ, e.rd);
`ifdef DMEM_ERR_EN
            check({tag, "_err"}, 32'(ERR), 32'(e.err));
`endif
        end
    endtask

    // Called at a negedge with the FSM in IDLE; returns at the negedge after the DONE cycle.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd,
                             input logic exp_err);
        exp_t e;
        int n, m;
        e.rd  = wr ? last_rd : exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        if (!wr) last_rd = exp_rd;
        CS = 1'b1; WR_RD = wr; ADDR = addr; Data_BUS_WRITE = wdata;
        @(negedge CLK);
        n = 1;
        CS = 1'b0; ADDR = ~addr; Data_BUS_WRITE = ~wdata;
        wait_ready(tag, m);
        n += m;
        if (READY === 1'b1) begin
            check({tag, "_latency"}, 32'(n), 32'(WS + 1));
            pop_check(tag);
        end else begin
            void'(sb.pop_front());
        end
        @(negedge CLK);
        check({tag, "_ready_pulse"}, 32'(READY), 32'd0);
    endtask

    initial begin
        int n1, n2, gap;
        RST = 1'b1; CS = 1'b0; WR_RD = 1'b0; ADDR = 32'd0; Data_BUS_WRITE = 32'd0;
        last_rd = 32'd0;

        // Reset: state after the first edge.
        @(negedge CLK);
        check("rst_rdata", Data_BUS_READ, 32'd0);
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
`ifdef DMEM_ERR_EN
        check("rst_err", 32'(ERR), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Write then read back the program result word.
        do_access("wr_result", 1'b1, 32'h0000_1B2F, 32'd4000000, 32'd0, 1'b0);
        do_access("rd_result", 1'b0, 32'h0000_1B2F, 32'd0, 32'd4000000, 1'b0);

        // Boundary words of the window.
        do_access("wr_lo", 1'b1, 32'h0000_1730, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_access("wr_hi", 1'b1, 32'h0000_1B2F, 32'h1234_5678, 32'd0, 1'b0);
        do_access("rd_lo", 1'b0, 32'h0000_1730, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_access("rd_hi", 1'b0, 32'h0000_1B2F, 32'd0, 32'h1234_5678, 1'b0);

        // Just past the top of the window.
`ifdef DMEM_ERR_EN
        do_access("oow_wr", 1'b1, 32'h0000_1B30, 32'd7, 32'd0, 1'b1);
        do_access("oow_rd", 1'b0, 32'h0000_1B30, 32'd0, 32'd0, 1'b1);
        do_access("base_intact", 1'b0, 32'h0000_1730, 32'd0, 32'hDEAD_BEEF, 1'b0);
`else
        do_access("wrap_wr", 1'b1, 32'h0000_1B30, 32'd7, 32'd0, 1'b0);
        do_access("wrap_rd", 1'b0, 32'h0000_1B30, 32'd0, 32'd7, 1'b0);
        do_access("wrap_base", 1'b0, 32'h0000_1730, 32'd0, 32'd7, 1'b0);
`endif

        // Reset during BUSY of a write discards it.
        do_access("wr_old", 1'b1, 32'h0000_1800, 32'h0000_0055, 32'd0, 1'b0);
        CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h0000_1800; Data_BUS_WRITE = 32'd99;
        @(negedge CLK);
        check("midrst_busy", 32'(dut.state_q), 32'd1);
        RST = 1'b1; CS = 1'b0;
        @(negedge CLK);
        check("midrst_ready0", 32'(READY), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'd0);
        check("midrst_rdata", Data_BUS_READ, 32'd0);
        RST = 1'b0;
        last_rd = 32'd0;
        @(negedge CLK);
        check("midrst_ready1", 32'(READY), 32'd0);
        do_access("rd_old", 1'b0, 32'h0000_1800, 32'd0, 32'h0000_0055, 1'b0);

        // Held CS: back-to-back reads.
        do_access("wr_a1", 1'b1, 32'h0000_1731, 32'h0000_00A1, 32'd0, 1'b0);
        do_access("wr_a2", 1'b1, 32'h0000_1732, 32'h0000_00A2, 32'd0, 1'b0);
        sb.push_back('{rd: 32'h0000_00A1, err: 1'b0});
        sb.push_back('{rd: 32'h0000_00A2, err: 1'b0});
        CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h0000_1731;
        wait_ready("held1", n1);
        check("held1_latency", 32'(n1), 32'(WS + 1));
        pop_check("held1");
        ADDR = 32'h0000_1732;
        @(negedge CLK);
        gap = 1;
        check("held_bubble", 32'(READY), 32'd0);
        wait_ready("held2", n2);
        gap += n2;
        check("held_spacing", 32'(gap), 32'(WS + 2));
        pop_check("held2");
        CS = 1'b0;
        @(negedge CLK);
        check("held2_ready_pulse", 32'(READY), 32'd0);
        check("held_hold", Data_BUS_READ, 32'h0000_00A2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
